// File: rtl/ppe_wrr_lock_if.sv
// Request/grant bundle for the packet-locking weighted round-robin arbiter.
// Requester i is bit [i] of the [0:N-1] vectors and bits [i*W +: W] of i_weight.
interface ppe_wrr_lock_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
);
  logic [0:N-1]   i_request;
  logic [0:N-1]   i_tail;
  logic [N*W-1:0] i_weight;
  logic           i_mode;
  logic [0:N-1]   o_grant;
  logic           o_locked;

  modport master (
    output i_request,
    output i_tail,
    output i_weight,
    output i_mode,
    input  o_grant,
    input  o_locked
  );

  modport slave (
    input  i_request,
    input  i_tail,
    input  i_weight,
    input  i_mode,
    output o_grant,
    output o_locked
  );
endinterface

// File: rtl/ppe_wrr_lock.sv
// Round-robin / weighted round-robin arbiter that holds the grant for the
// whole of a multi-flit packet and spends per-requester credit per packet.
module ppe_wrr_lock #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  ppe_wrr_lock_if.slave  bus
);

  localparam logic [0:N-1] PrioReset = {1'b1, {(N-1){1'b0}}};

  logic [0:N-1] prio_q, prio_d;
  logic         lock_q, lock_d;
  logic [0:N-1] owner_q, owner_d;
  logic [W-1:0] credit_q, credit_d;

  logic [0:N-1] grant;
  logic [0:N-1] next_oh;
  logic         grant_tail;
  logic [W-1:0] grant_weight;
  logic [W-1:0] ew, cur, c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q   <= PrioReset;
      lock_q   <= 1'b0;
      owner_q  <= '0;
      credit_q <= '0;
    end else if (ce) begin
      prio_q   <= prio_d;
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end

  // Output: grant is purely combinational from state and requests
  always_comb begin
    grant = '0;
    if (lock_q) begin
      // An idle owner yields a bubble; nobody else may take the slot.
      grant = owner_q & bus.i_request;
    end else begin
      for (int off = 0; off < N; off++) begin
        for (int i = 0; i < N; i++) begin
          if (prio_q[i] && bus.i_request[(i + off) % N] && (grant == '0)) begin
            grant[(i + off) % N] = 1'b1;
          end
        end
      end
    end
    bus.o_grant  = grant;
    bus.o_locked = lock_q;
  end

  // Next-state
  always_comb begin
    prio_d       = prio_q;
    lock_d       = lock_q;
    owner_d      = owner_q;
    credit_d     = credit_q;
    grant_tail   = |(grant & bus.i_tail);
    grant_weight = '0;
    next_oh      = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_weight = bus.i_weight[i*W +: W];
      next_oh[(i + 1) % N] = grant[i];
    end
    ew  = (bus.i_mode && (grant_weight != '0)) ? grant_weight : W'(1);
    cur = ((grant == prio_q) && (credit_q != '0)) ? credit_q : ew;
    c   = cur - W'(1);

    if (grant != '0) begin
      if (!grant_tail) begin
        lock_d  = 1'b1;
        owner_d = grant;
      end else begin
        lock_d  = 1'b0;
        owner_d = '0;
        if (c != '0) begin
          prio_d   = grant;
          credit_d = c;
        end else begin
          prio_d   = next_oh;
          credit_d = '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ppe_wrr_lock.sv
// Scoreboard bench for ppe_wrr_lock: directed scenarios plus randomized traffic
// checked against an integer-level arbitration model.
module tb_ppe_wrr_lock;
  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  always #5 clk = ~clk;

  ppe_wrr_lock_if #(.N(N), .W(W)) bus ();

  ppe_wrr_lock #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  typedef struct {
    logic [0:N-1] grant;
    logic         locked;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: plain integers for the priority pointer, owner and credit
  int m_prio, m_owner, m_credit;
  bit m_lock;
  bit m_valid = 1'b0;

  task automatic step(input logic [0:N-1] req, input logic [0:N-1] tail,
                      input logic [N*W-1:0] wt, input logic mode, input logic ce_v,
                      input logic rst_v, input string name, input bit use_const,
                      input logic [0:N-1] c_grant, input logic c_locked);
    int g, w, ew, cur, cc;
    logic [0:N-1] e_grant;
    exp_t e;
    @(posedge clk);
    #1;
    bus.i_request = req;
    bus.i_tail    = tail;
    bus.i_weight  = wt;
    bus.i_mode    = mode;
    ce            = ce_v;
    reset         = rst_v;

    g = -1;
    if (m_lock) begin
      if (req[m_owner]) g = m_owner;
    end else begin
      for (int off = 0; off < N; off++) begin
        if (g < 0 && req[(m_prio + off) % N]) g = (m_prio + off) % N;
      end
    end
    e_grant = '0;
    if (g >= 0) e_grant[g] = 1'b1;

    if (m_valid) begin
      e.name   = name;
      e.grant  = use_const ? c_grant : e_grant;
      e.locked = use_const ? c_locked : m_lock;
      sb.push_back(e);
    end

    if (rst_v) begin
      m_prio = 0; m_lock = 0; m_owner = -1; m_credit = 0; m_valid = 1'b1;
    end else if (ce_v && g >= 0) begin
      if (!tail[g]) begin
        m_lock = 1; m_owner = g;
      end else begin
        m_lock  = 0; m_owner = -1;
        w   = int'((wt >> (g * W)) & ((1 << W) - 1));
        ew  = mode ? ((w > 1) ? w : 1) : 1;
        cur = (g == m_prio && m_credit != 0) ? m_credit : ew;
        cc  = cur - 1;
        if (cc != 0) begin
          m_prio = g; m_credit = cc;
        end else begin
          m_prio = (g + 1) % N; m_credit = 0;
        end
      end
    end
  endtask

  task automatic chk(input logic [0:N-1] req, input logic [0:N-1] tail,
                     input logic [N*W-1:0] wt, input logic mode, input logic ce_v,
                     input logic rst_v, input string name,
                     input logic [0:N-1] c_grant, input logic c_locked);
    step(req, tail, wt, mode, ce_v, rst_v, name, 1'b1, c_grant, c_locked);
  endtask

  // Monitor: the DUT presents a grant every cycle; sample mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (bus.o_grant !== e.grant || bus.o_locked !== e.locked) begin
        n_fail++;
        $display("FAIL %s: got grant=%b locked=%b, expected grant=%b locked=%b",
                 e.name, bus.o_grant, bus.o_locked, e.grant, e.locked);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [0:N-1]   one0;
    logic [N*W-1:0] wts;
    int             pat[7];
    one0 = 4'b1000;
    wts  = 16'h1213;  // weights {0:3, 1:1, 2:2, 3:1}
    pat  = '{0, 0, 0, 1, 2, 2, 3};
    bus.i_request = '0; bus.i_tail = '0; bus.i_weight = '0; bus.i_mode = 1'b0;
    ce = 1'b1; reset = 1'b1;

    step(4'b0000, 4'b0000, '0, 1'b0, 1'b1, 1'b1, "init_reset", 1'b0, '0, 1'b0);
    chk(4'b0000, 4'b0000, '0, 1'b0, 1'b1, 1'b0, "reset_idle", 4'b0000, 1'b0);

    // Plain round robin, single-flit packets
    for (int k = 0; k < 8; k++)
      chk(4'b1111, 4'b1111, '0, 1'b0, 1'b1, 1'b0, "rr_rotate", one0 >> (k % 4), 1'b0);

    // Requester 0 served, then a 3-flit packet from 1 with stray tails elsewhere
    chk(4'b1111, 4'b1111, '0, 1'b0, 1'b1, 1'b0, "pkt_pre", 4'b1000, 1'b0);
    chk(4'b1111, 4'b1011, '0, 1'b0, 1'b1, 1'b0, "pkt_flit1", 4'b0100, 1'b0);
    chk(4'b1111, 4'b1011, '0, 1'b0, 1'b1, 1'b0, "pkt_flit2", 4'b0100, 1'b1);
    chk(4'b1111, 4'b0100, '0, 1'b0, 1'b1, 1'b0, "pkt_tail", 4'b0100, 1'b1);
    chk(4'b1111, 4'b1111, '0, 1'b0, 1'b1, 1'b0, "pkt_after", 4'b0010, 1'b0);

    // Locked owner goes idle: bubble, lock held
    chk(4'b1111, 4'b1111, '0, 1'b0, 1'b1, 1'b0, "bub_pre3", 4'b0001, 1'b0);
    chk(4'b1111, 4'b1111, '0, 1'b0, 1'b1, 1'b0, "bub_pre0", 4'b1000, 1'b0);
    chk(4'b1111, 4'b0000, '0, 1'b0, 1'b1, 1'b0, "bub_head", 4'b0100, 1'b0);
    chk(4'b1011, 4'b0000, '0, 1'b0, 1'b1, 1'b0, "bub_idle1", 4'b0000, 1'b1);
    chk(4'b1011, 4'b1111, '0, 1'b0, 1'b1, 1'b0, "bub_idle2", 4'b0000, 1'b1);
    chk(4'b1111, 4'b0100, '0, 1'b0, 1'b1, 1'b0, "bub_resume", 4'b0100, 1'b1);
    chk(4'b1111, 4'b1111, '0, 1'b0, 1'b1, 1'b0, "bub_after", 4'b0010, 1'b0);

    // Weighted round robin pattern
    step(4'b1111, 4'b1111, wts, 1'b1, 1'b1, 1'b1, "wrr_reset", 1'b0, '0, 1'b0);
    for (int k = 0; k < 14; k++)
      chk(4'b1111, 4'b1111, wts, 1'b1, 1'b1, 1'b0, "wrr_pattern", one0 >> pat[k % 7], 1'b0);

    // Weighted requester drops out after one grant, others get fresh credit
    step(4'b1111, 4'b1111, wts, 1'b1, 1'b1, 1'b1, "drop_reset", 1'b0, '0, 1'b0);
    chk(4'b1111, 4'b1111, wts, 1'b1, 1'b1, 1'b0, "drop_g0", 4'b1000, 1'b0);
    chk(4'b0111, 4'b1111, wts, 1'b1, 1'b1, 1'b0, "drop_g1", 4'b0100, 1'b0);
    chk(4'b1111, 4'b1111, wts, 1'b1, 1'b1, 1'b0, "drop_g2a", 4'b0010, 1'b0);
    chk(4'b1111, 4'b1111, wts, 1'b1, 1'b1, 1'b0, "drop_g2b", 4'b0010, 1'b0);
    chk(4'b1111, 4'b1111, wts, 1'b1, 1'b1, 1'b0, "drop_g3", 4'b0001, 1'b0);
    chk(4'b1111, 4'b1111, wts, 1'b1, 1'b1, 1'b0, "drop_g0back", 4'b1000, 1'b0);

    // Clock enable freeze mid-packet, then reset abandons the lock
    chk(4'b1111, 4'b0000, wts, 1'b1, 1'b1, 1'b0, "ce_head", 4'b1000, 1'b0);
    for (int k = 0; k < 3; k++)
      chk(4'b1111, 4'b1111, wts, 1'b1, 1'b0, 1'b0, "ce_frozen", 4'b1000, 1'b1);
    chk(4'b0110, 4'b1111, wts, 1'b1, 1'b1, 1'b1, "ce_reset", 4'b0000, 1'b1);
    chk(4'b0110, 4'b1111, wts, 1'b1, 1'b1, 1'b0, "ce_after_reset", 4'b0100, 1'b0);

    // Randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      logic [0:N-1] r, t;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b1111;
      t = 4'($urandom_range(0, 15));
      step(r, t, 16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 63) == 0), "random", 1'b0, '0, 1'b0);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending checks, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
